fetch_queue: RTL and testbench

- Parametrised successor of the single-word fetch stage.
- Accepts a group of up to FETCH_WIDTH sequential instruction words per cycle from the I-side.
- Per slot, computes pc, pcplus4 and the misaligned-PC exception flag, and enqueues the results into a circular buffer of DEPTH entries.
- Presents up to ISSUE_WIDTH oldest entries per cycle to decode and reports the sequential next-fetch PC to pcselect.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_slot.sv | 23 ++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the multi-issue fetch queue: entry layout and slot PC helper.
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  // Single-issue path record, kept alongside the queue entry type.
  typedef struct packed {
    word_t instr_;
    word_t pcplus4;
    logic  exception_instr;
  } fetch_data_t;

  typedef struct packed {
    word_t instr_;
    word_t pc;
    word_t pcplus4;
    logic  exception_instr;
  } fetch_entry_t;

  localparam int unsigned EntryW = $bits(fetch_entry_t);

  function automatic word_t slot_pc(word_t base, logic [1:0] idx);
    return base + {28'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-group input and decode-side output bundle of the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2
);
  localparam int unsigned CntW = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned AccW = $clog2(ISSUE_WIDTH + 1);

  logic                            in_valid;
  logic                            in_ready;
  word_t                           in_pc;
  logic [CntW-1:0]                 in_count;
  logic [FETCH_WIDTH*32-1:0]       in_instr;
  word_t                           pc_next;
  logic [ISSUE_WIDTH-1:0]          out_valid;
  logic [ISSUE_WIDTH*EntryW-1:0]   out_data;
  logic [AccW-1:0]                 out_accept;

  modport master (
    output in_valid, in_pc, in_count, in_instr, out_accept,
    input  in_ready, pc_next, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_pc, in_count, in_instr, out_accept,
    output in_ready, pc_next, out_valid, out_data
  );

endinterface

// File: rtl/fetch_queue_slot.sv
// Fetch slot: builds one queue entry from the group PC, slot index and word.
module fetch_queue_slot
  import fetch_queue_pkg::*;
(
  input  word_t        group_pc_i,
  input  logic [1:0]   slot_idx_i,
  input  word_t        instr_i,
  output fetch_entry_t entry_o
);

  word_t pc;

  assign pc = slot_pc(group_pc_i, slot_idx_i);

  // Misaligned words are still stored; the flag travels with them to decode.
  assign entry_o = '{
    instr_:          instr_i,
    pc:              pc,
    pcplus4:         pc + 32'd4,
    exception_instr: (pc[1:0] != 2'b00)
  };

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch queue: takes up to FETCH_WIDTH words per cycle, offers up to
// ISSUE_WIDTH oldest entries to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  fetch_queue_if.slave               fq,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];
  fetch_entry_t slot_entry [FETCH_WIDTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [OccW-1:0] count_q, count_d;
  logic [OccW-1:0] enq_n, deq_n;
  logic [31:0]     deq_lim;
  logic            in_ready;
  logic            count_legal;
  logic            enq_fire;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    fetch_queue_slot u_slot (
      .group_pc_i (fq.in_pc),
      .slot_idx_i (2'(i)),
      .instr_i    (fq.in_instr[32*i +: 32]),
      .entry_o    (slot_entry[i])
    );
  end

  // Readiness only looks at the registered count; a same-cycle dequeue gives no credit.
  assign in_ready    = (32'(count_q) + FETCH_WIDTH) <= DEPTH;
  assign count_legal = (fq.in_count != '0) && (32'(fq.in_count) <= FETCH_WIDTH);
  assign enq_fire    = fq.in_valid && in_ready && !flush && count_legal;
  assign enq_n       = enq_fire ? OccW'(fq.in_count) : '0;

  always_comb begin
    deq_lim = 32'(fq.out_accept);
    if (deq_lim > ISSUE_WIDTH) deq_lim = ISSUE_WIDTH;
    if (deq_lim > 32'(count_q)) deq_lim = 32'(count_q);
  end

  assign deq_n = flush ? '0 : OccW'(deq_lim);

  always_comb begin
    head_d  = head_q + PtrW'(deq_n);
    tail_d  = tail_q + PtrW'(enq_n);
    count_d = count_q + enq_n - deq_n;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (enq_fire && (i < 32'(fq.in_count))) begin
        mem[tail_q + PtrW'(i)] <= slot_entry[i];
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_out
    assign fq.out_valid[i]                  = count_q > OccW'(i);
    assign fq.out_data[i*EntryW +: EntryW]  = mem[head_q + PtrW'(i)];
  end

  assign fq.in_ready = in_ready;
  assign fq.pc_next  = fq.in_pc + (32'(fq.in_count) << 2);
  assign occupancy   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned FW = 2;
  localparam int unsigned IW = 2;
  localparam int unsigned DP = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [3:0] occupancy;

  fetch_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) fq ();

  fetch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DP)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .fq        (fq),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  fetch_entry_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic fetch_entry_t mk_entry(word_t pc, word_t w);
    fetch_entry_t e;
    e.instr_          = w;
    e.pc              = pc;
    e.pcplus4         = pc + 32'd4;
    e.exception_instr = (pc % 4) != 0;
    return e;
  endfunction

  function automatic fetch_entry_t slot_of(int i);
    return fetch_entry_t'(fq.out_data[i*EntryW +: EntryW]);
  endfunction

  // Advance one clock, updating the reference queue from the inputs held across the edge.
  task automatic tick();
    int  n_deq;
    bit  rdy;
    rdy   = (DP - mq.size()) >= FW;
    n_deq = int'(fq.out_accept);
    if (n_deq > IW) n_deq = IW;
    if (n_deq > mq.size()) n_deq = mq.size();
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      repeat (n_deq) void'(mq.pop_front());
      if (fq.in_valid && rdy)
        for (int k = 0; k < int'(fq.in_count); k++)
          mq.push_back(mk_entry(fq.in_pc + 32'(4 * k), fq.in_instr[32*k +: 32]));
    end
    #1;
  endtask

  task automatic set_group(word_t pc, int cnt);
    fq.in_valid = 1'b1;
    fq.in_pc    = pc;
    fq.in_count = 2'(cnt);
    fq.in_instr = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (fq.out_valid !== 2'b00) begin n_fail++;
      $display("FAIL reset_out_valid got=%b exp=00", fq.out_valid); end
    n_tests++; if (occupancy !== 4'd0) begin n_fail++;
      $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_tests++; if (fq.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got=%b exp=1", fq.in_ready); end
  endtask

  task automatic test_single_group();
    fetch_entry_t e0, e1;
    fq.in_valid = 1'b1; fq.in_pc = 32'hBFC0_0000; fq.in_count = 2'd2;
    fq.in_instr = {32'h2222_2222, 32'h1111_1111}; fq.out_accept = '0;
    #1;
    n_tests++; if (fq.pc_next !== 32'hBFC0_0008) begin n_fail++;
      $display("FAIL single_pc_next got=%h exp=bfc00008", fq.pc_next); end
    tick();
    fq.in_valid = 1'b0;
    #1;
    e0 = slot_of(0); e1 = slot_of(1);
    n_tests++; if (fq.out_valid !== 2'b11) begin n_fail++;
      $display("FAIL single_out_valid got=%b exp=11", fq.out_valid); end
    n_tests++; if (e0.pc !== 32'hBFC0_0000 || e0.pcplus4 !== 32'hBFC0_0004) begin n_fail++;
      $display("FAIL single_entry0 got=%h/%h exp=bfc00000/bfc00004", e0.pc, e0.pcplus4); end
    n_tests++; if (e1.pc !== 32'hBFC0_0004 || e1.pcplus4 !== 32'hBFC0_0008) begin n_fail++;
      $display("FAIL single_entry1 got=%h/%h exp=bfc00004/bfc00008", e1.pc, e1.pcplus4); end
    n_tests++; if (e0.instr_ !== 32'h1111_1111 || e1.instr_ !== 32'h2222_2222) begin n_fail++;
      $display("FAIL single_instr got=%h/%h exp=11111111/22222222", e0.instr_, e1.instr_); end
    n_tests++; if (occupancy !== 4'd2) begin n_fail++;
      $display("FAIL single_occupancy got=%0d exp=2", occupancy); end
  endtask

  task automatic test_fill_full();
    for (int g = 0; g < 3; g++) begin
      set_group(32'hBFC0_0008 + 32'(8 * g), 2);
      tick();
    end
    set_group(32'h0000_9000, 2);
    #1;
    n_tests++; if (occupancy !== 4'd8) begin n_fail++;
      $display("FAIL full_occupancy got=%0d exp=8", occupancy); end
    n_tests++; if (fq.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL full_in_ready got=%b exp=0", fq.in_ready); end
    tick();
    #1;
    n_tests++; if (occupancy !== 4'd8 || slot_of(0).pc !== 32'hBFC0_0000
                   || slot_of(1).pc !== 32'hBFC0_0004) begin n_fail++;
      $display("FAIL full_unchanged occ=%0d pc0=%h pc1=%h exp=8/bfc00000/bfc00004",
               occupancy, slot_of(0).pc, slot_of(1).pc); end
    // Full with same-cycle accept: the group must still be refused.
    fq.out_accept = 2'd2;
    #1;
    tick();
    fq.out_accept = '0;
    #1;
    n_tests++; if (occupancy !== 4'd6 || fq.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL full_accept occ=%0d ready=%b exp=6/1", occupancy, fq.in_ready); end
    tick();
    fq.in_valid = 1'b0;
    #1;
    n_tests++; if (occupancy !== 4'd8 || slot_of(0).pc !== 32'hBFC0_0008) begin n_fail++;
      $display("FAIL full_reaccept occ=%0d pc0=%h exp=8/bfc00008", occupancy, slot_of(0).pc); end
  endtask

  task automatic test_flush();
    fq.in_valid = 1'b0;
    fq.out_accept = 2'd2; tick();
    fq.out_accept = 2'd1; tick();
    fq.out_accept = '0;
    #1;
    n_tests++; if (occupancy !== 4'd5) begin n_fail++;
      $display("FAIL flush_pre_occ got=%0d exp=5", occupancy); end
    flush = 1'b1; set_group(32'h0000_4000, 2); fq.out_accept = 2'd2;
    tick();
    flush = 1'b0; fq.in_valid = 1'b0; fq.out_accept = '0;
    #1;
    n_tests++; if (occupancy !== 4'd0 || fq.out_valid !== 2'b00) begin n_fail++;
      $display("FAIL flush_clear occ=%0d valid=%b exp=0/00", occupancy, fq.out_valid); end
  endtask

  task automatic test_edge_pcs();
    fetch_entry_t e0, e1;
    set_group(32'h0040_0002, 2);
    tick();
    set_group(32'hFFFF_FFFC, 2); fq.out_accept = 2'd2;
    #1;
    e0 = slot_of(0); e1 = slot_of(1);
    n_tests++; if (e0.exception_instr !== 1'b1 || e1.exception_instr !== 1'b1) begin n_fail++;
      $display("FAIL misaligned_flag got=%b/%b exp=1/1", e0.exception_instr, e1.exception_instr); end
    n_tests++; if (e1.pc !== 32'h0040_0006 || e0.instr_ !== mq[0].instr_) begin n_fail++;
      $display("FAIL misaligned_data pc1=%h instr0=%h exp=00400006/%h", e1.pc, e0.instr_,
               mq[0].instr_); end
    tick();
    fq.in_valid = 1'b0; fq.out_accept = '0;
    #1;
    e0 = slot_of(0); e1 = slot_of(1);
    n_tests++; if (e1.pc !== 32'h0 || e0.pcplus4 !== 32'h0) begin n_fail++;
      $display("FAIL wrap_pc pc1=%h pcplus4_0=%h exp=0/0", e1.pc, e0.pcplus4); end
    n_tests++; if (e0.exception_instr !== 1'b0 || e1.exception_instr !== 1'b0) begin n_fail++;
      $display("FAIL wrap_flag got=%b/%b exp=0/0", e0.exception_instr, e1.exception_instr); end
    fq.out_accept = 2'd2; tick(); fq.out_accept = '0;
  endtask

  task automatic test_wrap();
    word_t exp_pc, nxt_pc;
    int    acc;
    exp_pc = 32'h0001_0000; nxt_pc = exp_pc;
    for (int c = 0; c < 10; c++) begin
      set_group(nxt_pc, 2);
      acc = (mq.size() >= 2) ? 2 : mq.size();
      fq.out_accept = 2'(acc);
      #1;
      if (c > 0) begin
        n_tests++; if (fq.out_valid[0] !== 1'b1 || slot_of(0).pc !== exp_pc) begin n_fail++;
          $display("FAIL wrap_seq cycle=%0d got=%h exp=%h", c, slot_of(0).pc, exp_pc); end
      end
      tick();
      exp_pc += 32'(4 * acc);
      nxt_pc += 32'd8;
    end
    fq.in_valid = 1'b0; fq.out_accept = 2'd2;
    #1;
    n_tests++; if (slot_of(0).pc !== exp_pc) begin n_fail++;
      $display("FAIL wrap_tail got=%h exp=%h", slot_of(0).pc, exp_pc); end
    tick();
    exp_pc += 32'd8;
    fq.out_accept = '0;
    #1;
    n_tests++; if (occupancy !== 4'd0 || exp_pc !== nxt_pc) begin n_fail++;
      $display("FAIL wrap_drain occ=%0d seen_end=%h exp=0/%h", occupancy, exp_pc, nxt_pc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      int unsigned r, sz, lim;
      logic [1:0]  exp_v;
      sz = mq.size();
      r  = $urandom;
      fq.in_valid = ($urandom_range(0, 3) != 0);
      fq.in_count = 2'($urandom_range(1, 2));
      fq.in_pc    = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
      fq.in_instr = {$urandom, $urandom};
      lim = (sz < 2) ? sz : 2;
      fq.out_accept = 2'($urandom_range(0, lim));
      #1;
      for (int i = 0; i < 2; i++) exp_v[i] = (sz > i);
      n_tests++; if (occupancy !== 4'(sz) || fq.out_valid !== exp_v) begin n_fail++;
        $display("FAIL rnd_state c=%0d occ=%0d valid=%b exp=%0d/%b", c, occupancy,
                 fq.out_valid, sz, exp_v); end
      n_tests++; if (fq.in_ready !== ((DP - sz) >= FW)) begin n_fail++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, fq.in_ready, (DP - sz) >= FW); end
      n_tests++; if (fq.pc_next !== fq.in_pc + 32'(4 * int'(fq.in_count))) begin n_fail++;
        $display("FAIL rnd_pc_next c=%0d got=%h", c, fq.pc_next); end
      for (int i = 0; i < 2; i++) begin
        if (i < sz) begin
          n_tests++; if (slot_of(i) !== mq[i]) begin n_fail++;
            $display("FAIL rnd_data c=%0d slot=%0d got=%h exp=%h", c, i, slot_of(i), mq[i]); end
        end
      end
      tick();
    end
    fq.in_valid = 1'b0; fq.out_accept = '0;
  endtask

  task automatic test_async_reset();
    set_group(32'h0000_2000, 1);
    tick();
    fq.in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    mq.delete();
    n_tests++; if (occupancy !== 4'd0 || fq.out_valid !== 2'b00 || fq.in_ready !== 1'b1)
    begin n_fail++;
      $display("FAIL async_reset occ=%0d valid=%b ready=%b exp=0/00/1", occupancy,
               fq.out_valid, fq.in_ready); end
    @(negedge clk);
    resetn = 1'b1;
    set_group(32'h0000_1000, 2);
    tick();
    fq.in_valid = 1'b0;
    #1;
    n_tests++; if (occupancy !== 4'd2 || slot_of(0) !== mq[0] || slot_of(1) !== mq[1])
    begin n_fail++;
      $display("FAIL post_reset occ=%0d pc0=%h pc1=%h exp=2/00001000/00001004", occupancy,
               slot_of(0).pc, slot_of(1).pc); end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    fq.in_valid = 1'b0; fq.in_pc = '0; fq.in_count = 2'd1; fq.in_instr = '0;
    fq.out_accept = '0;
    test_reset();
    #1;
    resetn = 1'b1;
    tick();
    test_single_group();
    test_fill_full();
    test_flush();
    test_edge_pcs();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
